// File: rtl/mlp_argmax_classifier.sv
// Serial signed argmax over a snapshot of the dense-layer activations, with a valid/ready result.
// Optional MLP_ARGMAX_MARGIN_EN adds class_margin (best minus second-best activation).
module mlp_argmax_classifier #(
  parameter int OUTPUT_WIDTH = 20,
  parameter int NUM_NEURONS  = 3,
  parameter int IDX_WIDTH    = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                layer_valid,
  input  logic [OUTPUT_WIDTH*NUM_NEURONS-1:0] outputs_flat,
  input  logic                                class_ready,
  output logic                                class_valid,
  output logic [IDX_WIDTH-1:0]                class_idx,
  output logic                                busy,
  output logic                                overrun
`ifdef MLP_ARGMAX_MARGIN_EN
  ,
  output logic [OUTPUT_WIDTH:0]               class_margin
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_NEURONS - 1);

  state_t                                   state;
  logic [NUM_NEURONS-1:0][OUTPUT_WIDTH-1:0] snap;
  logic [OUTPUT_WIDTH-1:0]                  best_val, elem, nxt_best, first;
  logic [IDX_WIDTH-1:0]                     best_idx, cnt, nxt_idx;
  logic                                     lv_q, new_res, capture, take;

  assign first   = outputs_flat[OUTPUT_WIDTH-1:0];
  assign new_res = layer_valid & ~lv_q;
  // A DONE handshake frees the slot in the same cycle, so a coincident edge is taken, not dropped.
  assign capture = new_res & ((state == IDLE) | ((state == DONE) & class_ready));

  always_comb begin
    elem = '0;
    for (int j = 0; j < NUM_NEURONS; j++)
      if (cnt == IDX_WIDTH'(j)) elem = snap[j];
  end

  assign take     = $signed(elem) > $signed(best_val);
  assign nxt_best = take ? elem : best_val;
  assign nxt_idx  = take ? cnt  : best_idx;

`ifdef MLP_ARGMAX_MARGIN_EN
  logic [OUTPUT_WIDTH-1:0] sec_val, nxt_sec;
  // sec_val starts at elem0; the first compare replaces it with a real runner-up.
  always_comb begin
    if (take)                                                        nxt_sec = best_val;
    else if ((cnt == IDX_WIDTH'(1)) || ($signed(elem) > $signed(sec_val))) nxt_sec = elem;
    else                                                             nxt_sec = sec_val;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lv_q        <= 1'b0;
      snap        <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      cnt         <= '0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
`ifdef MLP_ARGMAX_MARGIN_EN
      sec_val      <= '0;
      class_margin <= '0;
`endif
    end else begin
      lv_q    <= layer_valid;
      overrun <= new_res & ~capture;
      if (capture) begin
        snap     <= outputs_flat;
        best_val <= first;
        best_idx <= '0;
        cnt      <= IDX_WIDTH'(1);
        busy     <= 1'b1;
`ifdef MLP_ARGMAX_MARGIN_EN
        sec_val  <= first;
`endif
        if (NUM_NEURONS == 1) begin
          state       <= DONE;
          class_valid <= 1'b1;
          class_idx   <= '0;
`ifdef MLP_ARGMAX_MARGIN_EN
          class_margin <= '0;
`endif
        end else begin
          state       <= SCAN;
          class_valid <= 1'b0;
        end
      end else begin
        case (state)
          SCAN: begin
            best_val <= nxt_best;
            best_idx <= nxt_idx;
            cnt      <= cnt + 1'b1;
`ifdef MLP_ARGMAX_MARGIN_EN
            sec_val  <= nxt_sec;
`endif
            if (cnt == LAST) begin
              state       <= DONE;
              class_valid <= 1'b1;
              class_idx   <= nxt_idx;
`ifdef MLP_ARGMAX_MARGIN_EN
              class_margin <= {nxt_best[OUTPUT_WIDTH-1], nxt_best} - {nxt_sec[OUTPUT_WIDTH-1], nxt_sec};
`endif
            end
          end
          DONE: begin
            if (class_ready) begin
              state       <= IDLE;
              class_valid <= 1'b0;
              busy        <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlp_argmax_classifier.sv
// Directed table-driven bench for mlp_argmax_classifier (N=3), plus handshake/overrun/reset sequences.
module tb_mlp_argmax_classifier;
  localparam int W = 20;

  logic           clk = 1'b0, rst = 1'b1, layer_valid = 1'b0, class_ready = 1'b0;
  logic [3*W-1:0] outputs_flat = '0;
  logic           class_valid, busy, overrun;
  logic [2:0]     class_idx;
  int             tests = 0, fails = 0, cyc;

  always #5 clk = ~clk;

`ifdef MLP_ARGMAX_MARGIN_EN
  logic [W:0]     class_margin, m2_margin;
  logic           m2_rst = 1'b1, m2_lv = 1'b0, m2_valid, m2_busy, m2_ovr;
  logic [2*W-1:0] m2_flat = '0;
  logic [2:0]     m2_idx;
  mlp_argmax_classifier #(.OUTPUT_WIDTH(W), .NUM_NEURONS(2), .IDX_WIDTH(3)) dut2 (
    .clk(clk), .rst(m2_rst), .layer_valid(m2_lv), .outputs_flat(m2_flat), .class_ready(1'b1),
    .class_valid(m2_valid), .class_idx(m2_idx), .busy(m2_busy), .overrun(m2_ovr),
    .class_margin(m2_margin));
`endif

  mlp_argmax_classifier #(.OUTPUT_WIDTH(W), .NUM_NEURONS(3), .IDX_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .layer_valid(layer_valid), .outputs_flat(outputs_flat),
    .class_ready(class_ready), .class_valid(class_valid), .class_idx(class_idx),
    .busy(busy), .overrun(overrun)
`ifdef MLP_ARGMAX_MARGIN_EN
    , .class_margin(class_margin)
`endif
  );

  typedef struct {
    logic [W-1:0] n0, n1, n2;
    logic [2:0]   idx;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_flat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    outputs_flat = {c, b, a};
  endtask

  // Ticks until class_valid is seen or the budget runs out; cyc is the number of ticks taken.
  task automatic wait_valid();
    cyc = 0;
    while (!class_valid && cyc < 12) begin tick(); cyc++; end
  endtask

  initial begin
    vecs[0] = '{20'h10000, 20'h18000, 20'h30000, 3'd2};
    vecs[1] = '{20'hF0000, 20'hE0000, 20'hFFFFF, 3'd2};
    vecs[2] = '{20'h20000, 20'h20000, 20'h10000, 3'd0};
    vecs[3] = '{20'hFFFFF, 20'h80000, 20'hFFFFE, 3'd0};
    vecs[4] = '{20'h00001, 20'h7FFFF, 20'h80000, 3'd1};
    vecs[5] = '{20'h00005, 20'h00005, 20'h00005, 3'd0};

    tick(); tick();
    chk("reset_valid", class_valid, 0);
    chk("reset_idx", class_idx, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    rst = 1'b0; tick();

    for (int i = 0; i < 6; i++) begin
      set_flat(vecs[i].n0, vecs[i].n1, vecs[i].n2);
      layer_valid = 1'b1; class_ready = 1'b1;
      tick();
      chk("vec_busy_after_capture", busy, 1);
      chk("vec_valid_after_capture", class_valid, 0);
      wait_valid();
      chk("vec_latency", cyc, 2);
      chk("vec_idx", class_idx, vecs[i].idx);
      layer_valid = 1'b0;
      tick();
      chk("vec_valid_after_hs", class_valid, 0);
      chk("vec_busy_after_hs", busy, 0);
    end

    // Backpressure with a long layer_valid level and changing inputs.
    set_flat(20'h1, 20'h5, 20'h3);
    layer_valid = 1'b1; class_ready = 1'b0;
    tick(); wait_valid();
    chk("bp_latency", cyc, 2);
    for (int i = 0; i < 5; i++) begin
      set_flat(20'h9 + W'(i), 20'h0, 20'h0);
      tick();
      chk("bp_valid_hold", class_valid, 1);
      chk("bp_idx_hold", class_idx, 1);
      chk("bp_no_overrun", overrun, 0);
    end
    class_ready = 1'b1;
    tick();
    chk("bp_valid_drop", class_valid, 0);
    chk("bp_idle", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_single_result", busy, 0);
    end
    layer_valid = 1'b0; tick();

    // Second edge during SCAN is dropped; snapshot is isolated from later inputs.
    set_flat(20'h9, 20'h1, 20'h2);
    layer_valid = 1'b1; class_ready = 1'b0;
    tick();
    layer_valid = 1'b0; set_flat(20'h1, 20'h2, 20'h9);
    tick();
    layer_valid = 1'b1;
    tick();
    chk("ovr_pulse", overrun, 1);
    chk("ovr_valid", class_valid, 1);
    chk("ovr_idx", class_idx, 0);
    class_ready = 1'b1;
    tick();
    chk("ovr_pulse_end", overrun, 0);
    chk("ovr_hs_done", class_valid, 0);
    layer_valid = 1'b0; tick();

    // New edge in the same cycle as the DONE handshake is captured.
    set_flat(20'h1, 20'h9, 20'h2);
    layer_valid = 1'b1; class_ready = 1'b0;
    tick(); wait_valid();
    chk("hs_first_idx", class_idx, 1);
    layer_valid = 1'b0;
    tick();
    chk("hs_still_valid", class_valid, 1);
    set_flat(20'h7, 20'h1, 20'h2);
    layer_valid = 1'b1; class_ready = 1'b1;
    tick();
    chk("hs_no_overrun", overrun, 0);
    chk("hs_busy_scan", busy, 1);
    chk("hs_valid_low", class_valid, 0);
    wait_valid();
    chk("hs_latency", cyc, 2);
    chk("hs_second_idx", class_idx, 0);
    layer_valid = 1'b0; tick();

    // Reset mid-scan, then layer_valid held high across deassert.
    set_flat(20'h10000, 20'h18000, 20'h30000);
    layer_valid = 1'b1; class_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", class_valid, 0);
    chk("rst_mid_idx", class_idx, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_overrun", overrun, 0);
    rst = 1'b0;
    tick();
    chk("rst_recapture_busy", busy, 1);
    wait_valid();
    chk("rst_latency", cyc, 2);
    chk("rst_idx", class_idx, 2);
    layer_valid = 1'b0; tick();

`ifdef MLP_ARGMAX_MARGIN_EN
    set_flat(20'h10000, 20'h30000, 20'h28000);
    layer_valid = 1'b1; class_ready = 1'b1;
    tick(); wait_valid();
    chk("margin_idx", class_idx, 1);
    chk("margin_val", class_margin, 21'h08000);
    layer_valid = 1'b0; tick();
    m2_rst = 1'b0; m2_flat = {20'h80000, 20'h7FFFF}; m2_lv = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!m2_valid && cyc < 12);
    chk("m2_latency", cyc, 2);
    chk("m2_idx", m2_idx, 0);
    chk("m2_margin", m2_margin, 21'h0FFFFF);
    m2_lv = 1'b0; tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
